// File: rtl/halfadder_behavioural_pkg.sv
// halfadder_behavioural_pkg: default configuration shared by the half-adder slice
package halfadder_behavioural_pkg;
  localparam int HA_WIDTH = 1;
  localparam int HA_CNT_W = 16;
endpackage

// File: rtl/halfadder_behavioural_cell.sv
// half_adder_cell: single-lane combinational half adder
module half_adder_cell
  import halfadder_behavioural_pkg::*;
(
  input  logic a,
  input  logic b,
  output logic sum,
  output logic carry
);
  assign sum = a ^ b;
  assign carry = a & b;
endmodule

// File: rtl/halfadder_behavioural.sv
// halfadder_behavioural: parallel half-adder lanes with registered outputs and saturating carry counter
module halfadder_behavioural
  import halfadder_behavioural_pkg::*;
#(
  parameter int WIDTH = HA_WIDTH,
  parameter int CNT_W = HA_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic [WIDTH-1:0] carry,
  output logic [WIDTH-1:0] sum_q,
  output logic [WIDTH-1:0] carry_q,
  output logic [CNT_W-1:0] carry_cnt
);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    half_adder_cell u_cell (.a(a[i]), .b(b[i]), .sum(sum[i]), .carry(carry[i]));
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q <= '0;
      carry_q <= '0;
      carry_cnt <= '0;
    end else begin
      sum_q <= sum;
      carry_q <= carry;
      if (|carry && carry_cnt != CNT_MAX) carry_cnt <= carry_cnt + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_halfadder_behavioural.sv
// tb_halfadder_behavioural: scoreboard bench over default, 2-bit-counter and 4-lane configurations
module tb_halfadder_behavioural;
  logic clk = 0;
  logic rst;
  logic a1, b1, a2, b2;
  logic [3:0] a4, b4;
  logic s1, c1, sq1, cq1, s2, c2, sq2, cq2;
  logic [15:0] cnt1, cnt4;
  logic [1:0] cnt2;
  logic [3:0] s4, c4, sq4, cq4;

  halfadder_behavioural u1 (.clk(clk), .rst(rst), .a(a1), .b(b1), .sum(s1), .carry(c1),
    .sum_q(sq1), .carry_q(cq1), .carry_cnt(cnt1));
  halfadder_behavioural #(.WIDTH(1), .CNT_W(2)) u2 (.clk(clk), .rst(rst), .a(a2), .b(b2),
    .sum(s2), .carry(c2), .sum_q(sq2), .carry_q(cq2), .carry_cnt(cnt2));
  halfadder_behavioural #(.WIDTH(4), .CNT_W(16)) u4 (.clk(clk), .rst(rst), .a(a4), .b(b4),
    .sum(s4), .carry(c4), .sum_q(sq4), .carry_q(cq4), .carry_cnt(cnt4));

  always #5 clk = ~clk;

  typedef enum int {S1, C1, SQ1, CQ1, CNT1, CNT2, S4, C4, SQ4, CQ4, CNT4} sig_t;
  typedef struct {sig_t sig; logic [15:0] exp; string name;} exp_t;
  exp_t q[$];
  int checks = 0;
  int errors = 0;

  function automatic logic [15:0] actual(sig_t s);
    case (s)
      S1: return {15'd0, s1};
      C1: return {15'd0, c1};
      SQ1: return {15'd0, sq1};
      CQ1: return {15'd0, cq1};
      CNT1: return cnt1;
      CNT2: return {14'd0, cnt2};
      S4: return {12'd0, s4};
      C4: return {12'd0, c4};
      SQ4: return {12'd0, sq4};
      CQ4: return {12'd0, cq4};
      default: return cnt4;
    endcase
  endfunction

  task automatic expect_v(sig_t s, logic [15:0] e, string n);
    q.push_back('{s, e, n});
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    while (q.size() > 0) begin
      exp_t e;
      logic [15:0] act;
      e = q.pop_front();
      act = actual(e.sig);
      checks++;
      if (act !== e.exp) begin
        errors++;
        $display("FAIL %s: got %0h expected %0h", e.name, act, e.exp);
      end
    end
  end

  initial begin
    rst = 1;
    a1 = 0; b1 = 0; a2 = 0; b2 = 0; a4 = 4'b1100; b4 = 4'b1010;
    cyc();
    cyc();
    expect_v(SQ1, 0, "reset_sum_q");
    expect_v(CQ1, 0, "reset_carry_q");
    expect_v(CNT1, 0, "reset_cnt");
    expect_v(CNT2, 0, "reset_cnt_w2");
    expect_v(S4, 16'b0110, "lanes_sum");
    expect_v(C4, 16'b1000, "lanes_carry");
    expect_v(CQ4, 0, "reset_carry_q_w4");
    // truth table while rst is held: comb outputs must still follow a/b
    for (int v = 0; v < 4; v++) begin
      cyc();
      {a1, b1} = v[1:0];
      expect_v(S1, (v == 1 || v == 2) ? 16'd1 : 16'd0, $sformatf("tt_sum_%0d", v));
      expect_v(C1, (v == 3) ? 16'd1 : 16'd0, $sformatf("tt_carry_%0d", v));
    end
    cyc();
    expect_v(CQ1, 0, "carry_q_held_in_reset");
    expect_v(CNT1, 0, "cnt_held_in_reset");
    rst = 0; a2 = 1; b2 = 1;
    cyc();
    expect_v(CQ1, 1, "carry_q_11");
    expect_v(SQ1, 0, "sum_q_11");
    expect_v(CNT1, 1, "cnt_first");
    expect_v(CNT2, 1, "cnt_w2_1");
    expect_v(SQ4, 16'b0110, "lanes_sum_q");
    expect_v(CQ4, 16'b1000, "lanes_carry_q");
    expect_v(CNT4, 1, "lanes_cnt");
    a4 = 4'b1111; b4 = 4'b0001;
    cyc();
    expect_v(S4, 16'b1110, "lanes_sum_b");
    expect_v(C4, 16'b0001, "lanes_carry_b");
    expect_v(CNT2, 2, "cnt_w2_2");
    repeat (3) cyc();
    expect_v(CNT1, 5, "cnt_five");
    expect_v(CNT2, 3, "cnt_w2_sat");
    expect_v(CQ4, 16'b0001, "lanes_carry_q_b");
    a1 = 1; b1 = 0; a4 = 4'b0101; b4 = 4'b1010;
    repeat (3) cyc();
    expect_v(CNT1, 5, "cnt_no_carry");
    expect_v(SQ1, 1, "sum_q_10");
    expect_v(CQ1, 0, "carry_q_10");
    expect_v(CNT2, 3, "cnt_w2_stays");
    expect_v(SQ4, 16'b1111, "lanes_sum_q_c");
    expect_v(CNT4, 5, "lanes_cnt_hold");
    a1 = 1; b1 = 1;
    cyc();
    expect_v(CNT1, 6, "cnt_resume");
    rst = 1;
    cyc();
    expect_v(SQ1, 0, "mid_rst_sum_q");
    expect_v(CQ1, 0, "mid_rst_carry_q");
    expect_v(CNT1, 0, "mid_rst_cnt");
    expect_v(C1, 1, "mid_rst_comb_carry");
    expect_v(CNT2, 0, "mid_rst_cnt_w2");
    rst = 0;
    cyc();
    expect_v(CNT1, 1, "post_rst_cnt");
    expect_v(CQ1, 1, "post_rst_carry_q");
    expect_v(CNT2, 1, "post_rst_cnt_w2");
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
